multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Control sequencer for the multicycle RV32I-subset core; replaces the single-cycle control unit when one shared memory and one shared ALU serve all instruction phases.
- A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback phases.
- Drives datapath mux selects and write enables, plus combinational immSrc and ALUcontrol decoders.
- Honours a memory ready handshake so slow memory can stall the machine.

Parameters:
- STALL_EN, default 1: 1 = FETCH/MEMREAD/MEMWRITE wait for memReady; 0 = memReady ignored (treated as 1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  7  opcode from instruction register
- funct3  in  3  instr[14:12]
- funct7  in  1  instr[30]
- zero  in  1  ALU zero flag
- memReady  in  1  memory access complete this cycle
- pcWrite  out  1  PC register enable
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- memWrite  out  1  memory write enable
- irWrite  out  1  IR/oldPC enable
- regWrite  out  1  register file write enable
- resultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- aluSrcA  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
- aluSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4
- immSrc  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J
- ALUcontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset = 1 at a clock edge sets state = FETCH (0).
  - While reset is high, pcWrite, memWrite, irWrite, regWrite and illegal are forced to 0.
  - Reset asserted mid-instruction abandons it; no partial write occurs after the reset edge.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10.
- Unused encodings 11–15 go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE when memReady; otherwise hold.
  - DECODE by op:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other opcode → FETCH, with illegal = 1 during that DECODE cycle.
  - MEMADR → MEMREAD if op = lw, else MEMWRITE.
  - MEMREAD → MEMWB when memReady; otherwise hold.
  - MEMWRITE → FETCH when memReady; otherwise hold.
  - MEMWB → FETCH.
  - EXECUTER and EXECUTEI → ALUWB.
  - ALUWB → FETCH.
  - BEQ → FETCH.
  - JAL → ALUWB.
- Outputs per state (unlisted outputs are 0):
  - FETCH: adrSrc = 0, aluSrcA = 00, aluSrcB = 10, resultSrc = 10; irWrite = memReady; pcUpdate = memReady.
  - DECODE: aluSrcA = 01, aluSrcB = 01 (branch target into ALUOut).
  - MEMADR: aluSrcA = 10, aluSrcB = 01.
  - MEMREAD: adrSrc = 1.
  - MEMWB: resultSrc = 01, regWrite = 1.
  - MEMWRITE: adrSrc = 1, memWrite = 1. memWrite stays asserted through every stall cycle.
  - EXECUTER: aluSrcA = 10, aluSrcB = 00, aluOp = 10.
  - EXECUTEI: aluSrcA = 10, aluSrcB = 01, aluOp = 10.
  - ALUWB: resultSrc = 00, regWrite = 1.
  - BEQ: aluSrcA = 10, aluSrcB = 00, aluOp = 01, resultSrc = 00, branch = 1.
  - JAL: aluSrcA = 01, aluSrcB = 10, resultSrc = 00, pcUpdate = 1.
- pcWrite = (branch & zero) | pcUpdate.
- Instruction latencies with memReady tied high:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
  - Each memReady = 0 cycle adds one cycle to FETCH, MEMREAD or MEMWRITE.
- ALU decode (combinational):
  - aluOp 00 → add; aluOp 01 → sub.
  - aluOp 10, by funct3:
    - 000: sub if op[5] & funct7, else add
    - 010: slt
    - 110: or
    - 111: and
    - other: add
- immSrc (combinational, by op): lw/I-type 00, sw 01, beq 10, jal 11; any other opcode 00.

Test Plan:
- lw, memReady = 1: states 0 → 1 → 2 → 3 → 4 → 0; regWrite = 1 only in MEMWB with resultSrc = 01; pcWrite = 1 only in the FETCH cycle.
- sw, memReady low 3 cycles in MEMWRITE: memWrite = 1 for 4 consecutive cycles, adrSrc = 1, then FETCH; regWrite stays 0.
- add/sub: op = 0110011, funct3 = 000, funct7 = 1 → ALUcontrol = 001 in EXECUTER; with funct7 = 0 → 000; ALUWB asserts regWrite.
- beq: zero = 1 → pcWrite = 1 in the BEQ cycle; zero = 0 → pcWrite = 0; both cases return to FETCH after 3 cycles total.
- Illegal op = 0000000: illegal pulses for exactly one cycle in DECODE; next state is FETCH; no write enable asserts.
- Reset in MEMWRITE during a stall: the next state is FETCH, memWrite drops to 0 on the reset cycle, and state output reads 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Moore control sequencer for a multicycle RV32I-subset core.
//               Steps each instruction through fetch, decode, execute,
//               memory and writeback phases over one shared memory and one
//               shared ALU. Also decodes immSrc and ALUcontrol
//               combinationally. A memory-ready handshake stalls FETCH,
//               MEMREAD and MEMWRITE until the access completes.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               op, funct3, funct7    - instruction fields from the IR
//               zero                  - ALU zero flag (branch resolution)
//               memReady              - memory access completes this cycle
//               pcWrite, adrSrc, memWrite, irWrite, regWrite,
//               resultSrc, aluSrcA, aluSrcB - datapath enables and selects
//               immSrc, ALUcontrol    - immediate type and ALU operation
//               illegal               - pulse on an unsupported opcode
//               state                 - current state, for debug
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int STALL_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] immSrc,
  output logic [2:0] ALUcontrol,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       mem_rdy;

  // With stalling disabled the machine behaves as if memory is always ready.
  generate
    if (STALL_EN != 0) begin : g_stall
      assign mem_rdy = memReady;
    end else begin : g_no_stall
      assign mem_rdy = 1'b1;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;  // unused encodings recover to FETCH
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-state outputs
  // --------------------------------------------------------------------------
  logic       pc_update;
  logic       branch;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       illegal_raw;
  logic [1:0] alu_op;

  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    alu_op        = ALUOP_ADD;
    adrSrc        = 1'b0;
    resultSrc     = 2'b00;
    aluSrcA       = 2'b00;
    aluSrcB       = 2'b00;
    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed on ALUResult and written straight to the PC.
        aluSrcB      = 2'b10;
        resultSrc    = 2'b10;
        ir_write_raw = mem_rdy;
        pc_update    = mem_rdy;
      end
      S_DECODE: begin
        // oldPC + imm lands in ALUOut so BEQ can use it as the target.
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: illegal_raw = 1'b0;
          default:                                           illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      S_MEMREAD: begin
        adrSrc = 1'b1;
      end
      S_MEMWB: begin
        resultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        // Held for the whole stall so the slow memory sees a stable request.
        adrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b00;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        resultSrc     = 2'b00;
        reg_write_raw = 1'b1;
      end
      S_BEQ: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b00;
        alu_op    = ALUOP_SUB;
        resultSrc = 2'b00;
        branch    = 1'b1;
      end
      S_JAL: begin
        // PC <- branch target held in ALUOut; oldPC + 4 goes to ALUOut for rd.
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        resultSrc = 2'b00;
        pc_update = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase
  end

  // Enables are squashed while reset is high so an abandoned instruction
  // cannot commit anything in the reset cycle itself.
  assign pcWrite  = ~reset & ((branch & zero) | pc_update);
  assign memWrite = ~reset & mem_write_raw;
  assign irWrite  = ~reset & ir_write_raw;
  assign regWrite = ~reset & reg_write_raw;
  assign illegal  = ~reset & illegal_raw;
  assign state    = state_q;

  // --------------------------------------------------------------------------
  // ALU operation decode
  // --------------------------------------------------------------------------
  always_comb begin
    ALUcontrol = 3'b000;
    case (alu_op)
      ALUOP_ADD: ALUcontrol = 3'b000;
      ALUOP_SUB: ALUcontrol = 3'b001;
      default: begin
        case (funct3)
          // op[5] separates R-type sub from I-type addi with imm[10] set.
          3'b000:  ALUcontrol = (op[5] & funct7) ? 3'b001 : 3'b000;
          3'b010:  ALUcontrol = 3'b101;
          3'b110:  ALUcontrol = 3'b011;
          3'b111:  ALUcontrol = 3'b010;
          default: ALUcontrol = 3'b000;
        endcase
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Immediate type decode
  // --------------------------------------------------------------------------
  always_comb begin
    immSrc = 2'b00;
    case (op)
      OP_LW, OP_ITYPE: immSrc = 2'b00;
      OP_SW:           immSrc = 2'b01;
      OP_BEQ:          immSrc = 2'b10;
      OP_JAL:          immSrc = 2'b11;
      default:         immSrc = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Self-checking bench for multicycle_control_fsm. Each
//               instruction is expanded into the cycle-by-cycle list of
//               phases it must pass through (including memory stalls), and
//               the DUT is compared against that list every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       zero;
  logic       memReady;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0] ALUcontrol;
  logic [3:0] state;

  multicycle_control_fsm #(.STALL_EN(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .zero       (zero),
    .memReady   (memReady),
    .pcWrite    (pcWrite),
    .adrSrc     (adrSrc),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .regWrite   (regWrite),
    .resultSrc  (resultSrc),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .immSrc     (immSrc),
    .ALUcontrol (ALUcontrol),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Instruction kinds
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  // One expected cycle. wen = {pcWrite,memWrite,irWrite,regWrite,illegal},
  // mux = {adrSrc,resultSrc,aluSrcA,aluSrcB}.
  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic [4:0] wen;
    logic [6:0] mux;
    logic [2:0] alu;
  } rec_t;

  rec_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic       cur_z;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation an R-type (is_r=1) or I-type instruction asks for.
  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  task automatic add_cyc(input logic [3:0] st, input logic mr, input logic [4:0] wen,
                         input logic [6:0] mux, input logic [2:0] alu);
    rec_t r;
    r.st = st; r.mr = mr; r.op = cur_op; r.f3 = cur_f3; r.f7 = cur_f7; r.z = cur_z;
    r.wen = wen; r.mux = mux; r.alu = alu;
    q.push_back(r);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its expected cycles. fs/ms are the number of
  // memReady-low cycles in the fetch and in the data access respectively.
  task automatic add_instr(input int kind, input logic [2:0] f3, input logic f7,
                           input logic z, input int fs, input int ms, input logic [6:0] ill_op);
    case (kind)
      K_LW:    cur_op = 7'b0000011;
      K_SW:    cur_op = 7'b0100011;
      K_R:     cur_op = 7'b0110011;
      K_I:     cur_op = 7'b0010011;
      K_BEQ:   cur_op = 7'b1100011;
      K_JAL:   cur_op = 7'b1101111;
      default: cur_op = ill_op;
    endcase
    cur_f3 = f3; cur_f7 = f7; cur_z = z;
    for (int i = 0; i < fs; i++) add_cyc(4'd0, 1'b0, 5'b00000, 7'b0_10_00_10, 3'd0);
    add_cyc(4'd0, 1'b1, 5'b10100, 7'b0_10_00_10, 3'd0);
    add_cyc(4'd1, rbit(), {4'b0000, kind == K_ILL}, 7'b0_00_01_01, 3'd0);
    case (kind)
      K_LW: begin
        add_cyc(4'd2, rbit(), 5'b00000, 7'b0_00_10_01, 3'd0);
        for (int i = 0; i < ms; i++) add_cyc(4'd3, 1'b0, 5'b00000, 7'b1_00_00_00, 3'd0);
        add_cyc(4'd3, 1'b1, 5'b00000, 7'b1_00_00_00, 3'd0);
        add_cyc(4'd4, rbit(), 5'b00010, 7'b0_01_00_00, 3'd0);
      end
      K_SW: begin
        add_cyc(4'd2, rbit(), 5'b00000, 7'b0_00_10_01, 3'd0);
        for (int i = 0; i < ms; i++) add_cyc(4'd5, 1'b0, 5'b01000, 7'b1_00_00_00, 3'd0);
        add_cyc(4'd5, 1'b1, 5'b01000, 7'b1_00_00_00, 3'd0);
      end
      K_R: begin
        add_cyc(4'd6, rbit(), 5'b00000, 7'b0_00_10_00, ref_alu(f3, f7, 1'b1));
        add_cyc(4'd8, rbit(), 5'b00010, 7'b0_00_00_00, 3'd0);
      end
      K_I: begin
        add_cyc(4'd7, rbit(), 5'b00000, 7'b0_00_10_01, ref_alu(f3, f7, 1'b0));
        add_cyc(4'd8, rbit(), 5'b00010, 7'b0_00_00_00, 3'd0);
      end
      K_BEQ: add_cyc(4'd9, rbit(), {z, 4'b0000}, 7'b0_00_10_00, 3'd1);
      K_JAL: begin
        add_cyc(4'd10, rbit(), 5'b10000, 7'b0_00_01_10, 3'd0);
        add_cyc(4'd8, rbit(), 5'b00010, 7'b0_00_00_00, 3'd0);
      end
      default: ;
    endcase
  endtask

  // Called just after a rising edge: drive one cycle, check mid-cycle.
  task automatic step(input rec_t r);
    op = r.op; funct3 = r.f3; funct7 = r.f7; zero = r.z; memReady = r.mr;
    @(negedge clk);
    check_val("state", {28'd0, state}, {28'd0, r.st});
    check_val("wen",   {27'd0, pcWrite, memWrite, irWrite, regWrite, illegal}, {27'd0, r.wen});
    check_val("mux",   {25'd0, adrSrc, resultSrc, aluSrcA, aluSrcB}, {25'd0, r.mux});
    check_val("alu",   {29'd0, ALUcontrol}, {29'd0, r.alu});
    check_val("imm",   {30'd0, immSrc}, {30'd0, ref_imm(r.op)});
    @(posedge clk); #1;
  endtask

  task automatic run_queue();
    while (q.size() > 0) step(q.pop_front());
  endtask

  logic [6:0] ill_ops [4];

  initial begin
    ill_ops[0] = 7'b0000000; ill_ops[1] = 7'b0110111;
    ill_ops[2] = 7'b1100111; ill_ops[3] = 7'b1110011;
    reset = 1'b1; op = 7'b0100011; funct3 = 3'd0; funct7 = 1'b0; zero = 1'b0; memReady = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_wen", {27'd0, pcWrite, memWrite, irWrite, regWrite, illegal}, 32'd0);
    check_val("rst_state", {28'd0, state}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed instructions from the plan
    add_instr(K_LW,  3'd2, 1'b0, 1'b0, 0, 0, 7'd0);
    add_instr(K_SW,  3'd2, 1'b0, 1'b0, 0, 3, 7'd0);
    add_instr(K_R,   3'd0, 1'b1, 1'b0, 0, 0, 7'd0);
    add_instr(K_R,   3'd0, 1'b0, 1'b0, 0, 0, 7'd0);
    add_instr(K_BEQ, 3'd0, 1'b0, 1'b1, 0, 0, 7'd0);
    add_instr(K_BEQ, 3'd0, 1'b0, 1'b0, 0, 0, 7'd0);
    add_instr(K_ILL, 3'd0, 1'b0, 1'b0, 0, 0, 7'b0000000);
    add_instr(K_I,   3'd0, 1'b1, 1'b0, 1, 0, 7'd0);
    add_instr(K_JAL, 3'd0, 1'b0, 1'b0, 2, 0, 7'd0);
    run_queue();

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      add_instr($urandom_range(0, 6), 3'($urandom_range(0, 7)), rbit(), rbit(),
                $urandom_range(0, 3), $urandom_range(0, 3), ill_ops[$urandom_range(0, 3)]);
      run_queue();
    end

    // Reset in the middle of a stalled store
    add_instr(K_SW, 3'd0, 1'b0, 1'b0, 0, 5, 7'd0);
    while (q.size() > 0 && q[0].st != 4'd5) step(q.pop_front());
    step(q.pop_front());          // one MEMWRITE stall cycle
    q.delete();
    reset = 1'b1; memReady = 1'b0;
    @(negedge clk);
    check_val("rst_mid_state", {28'd0, state}, 32'd5);
    check_val("rst_mid_wen", {27'd0, pcWrite, memWrite, irWrite, regWrite, illegal}, 32'd0);
    @(posedge clk); #1;
    check_val("rst_mid_after", {28'd0, state}, 32'd0);
    reset = 1'b0;
    add_instr(K_LW, 3'd0, 1'b0, 1'b0, 1, 1, 7'd0);
    run_queue();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
